// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with prefetch queue and redirect handling
// Purpose: issues sequential word fetches to a variable-latency instruction memory.
//          Each returned word is tagged with its PC and buffered in an in-order
//          prefetch queue. The head of the queue is presented to the core.
//          A redirect flushes the queue and discards responses still in flight,
//          then restarts fetch at the new PC.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   imem_req_valid/ready     fetch request handshake
//   imem_req_addr            word-aligned fetch address (always the current fetch PC)
//   imem_rsp_valid/data      in-order response word from instruction memory
//   redirect_valid/pc        restart fetch at redirect_pc (low two bits ignored)
//   instr_valid/ready        queue head handshake towards the core
//   instr, instr_pc          queue head word and its PC (registered)
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [31:0]   tag_q   [DEPTH];
   logic [31:0]   tag_d   [DEPTH];
   logic [31:0]   qpc_q   [DEPTH];
   logic [31:0]   qpc_d   [DEPTH];
   logic [31:0]   qdata_q [DEPTH];
   logic [31:0]   qdata_d [DEPTH];

   logic          pop, rsp, keep, accept, req_ok;
   logic [CW:0]   occ;
   logic [1:0]    unused_redirect_lsb;

   assign unused_redirect_lsb = redirect_pc[1:0];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      pop    = (count_q != '0) & instr_ready;
      rsp    = imem_rsp_valid;
      // Credit check: a slot freed by this cycle's pop can be reused by this cycle's request.
      occ    = (CW+1)'(outstanding_q) + (CW+1)'(count_q) - (CW+1)'(pop);
      req_ok = rst & ~redirect_valid & (occ < (CW+1)'(DEPTH));
      accept = req_ok & imem_req_ready;
      // Responses belonging to pre-redirect requests (or arriving in a redirect cycle) are dropped.
      keep   = rsp & ~redirect_valid & (discard_q == '0);

      fetch_pc_d    = fetch_pc_q;
      outstanding_d = outstanding_q + CW'(accept) - CW'(rsp);
      discard_d     = discard_q;
      count_d       = count_q;
      tag_wr_d      = tag_wr_q;
      tag_rd_d      = tag_rd_q;
      head_d        = head_q;
      tail_d        = tail_q;
      tag_d         = tag_q;
      qpc_d         = qpc_q;
      qdata_d       = qdata_q;

      // The tag FIFO tracks every in-flight request, discarded or not, so tags
      // of dropped responses are consumed as those responses drain.
      if (accept) begin
         tag_d[tag_wr_q] = fetch_pc_q;
         tag_wr_d        = ptr_inc(tag_wr_q);
         fetch_pc_d      = fetch_pc_q + 32'd4;
      end
      if (rsp) begin
         tag_rd_d = ptr_inc(tag_rd_q);
      end

      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         discard_d  = outstanding_q - CW'(rsp);
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
      end else begin
         if (rsp && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
         end
         if (keep) begin
            qpc_d[tail_q]   = tag_q[tag_rd_q];
            qdata_d[tail_q] = imem_rsp_data;
            tail_d          = ptr_inc(tail_q);
         end
         if (pop) begin
            head_d = ptr_inc(head_q);
         end
         count_d = count_q + CW'(keep) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
         count_q       <= '0;
         tag_wr_q      <= '0;
         tag_rd_q      <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         tag_q         <= '{default: '0};
         qpc_q         <= '{default: '0};
         qdata_q       <= '{default: '0};
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         count_q       <= count_d;
         tag_wr_q      <= tag_wr_d;
         tag_rd_q      <= tag_rd_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         tag_q         <= tag_d;
         qpc_q         <= qpc_d;
         qdata_q       <= qdata_d;
      end
   end

   assign imem_req_valid = req_ok;
   assign imem_req_addr  = fetch_pc_q;
   assign instr_valid    = (count_q != '0);
   // Head is gated so the outputs read zero whenever the queue is empty.
   assign instr          = instr_valid ? qdata_q[head_q] : 32'h0;
   assign instr_pc       = instr_valid ? qpc_q[head_q]   : 32'h0;

   a_rsp_with_outstanding: assert property (@(posedge clk) disable iff (!rst)
      imem_rsp_valid |-> (outstanding_q != '0));
   a_discard_bound: assert property (@(posedge clk) disable iff (!rst)
      discard_q <= outstanding_q);
   a_occupancy_bound: assert property (@(posedge clk) disable iff (!rst)
      ((CW+1)'(outstanding_q) + (CW+1)'(count_q)) <= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with memory model and PC-stream scoreboard
module tb_fetch_unit;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid, instr_ready;
   logic [31:0] instr, instr_pc;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
      int          epoch;
   } pend_t;

   pend_t       pend_q[$];
   logic [31:0] popped_q[$];
   int          total = 0, bad = 0, cyc = 0, epoch = 0, buf_cnt = 0;
   int          lat_min = 1, lat_max = 1;
   logic        mem_ready = 1'b1;
   logic [31:0] exp_pc = RESET_PC, exp_req_addr = RESET_PC;

   function automatic logic [31:0] img(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5a3c_96e1;
   endfunction

   // One clock cycle: drive memory response, sample at negedge, score, advance the model.
   // The model tracks the PC stream the core should see and how many live words are buffered.
   task automatic tick();
      pend_t e;
      logic  pop_m, live, exp_rv;
      int    occ;
      imem_req_ready = mem_ready;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = img(pend_q[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      @(negedge clk);
      pop_m  = (buf_cnt != 0) && instr_ready;
      occ    = pend_q.size() + buf_cnt - int'(pop_m);
      exp_rv = !redirect_valid && (occ < DEPTH);
      total++;
      if (instr_valid !== (buf_cnt != 0)) begin
         bad++;
         $display("FAIL instr_valid cyc=%0d got=%b want=%b", cyc, instr_valid, buf_cnt != 0);
      end
      if (buf_cnt != 0) begin
         total++;
         if (instr_pc !== exp_pc || instr !== img(exp_pc)) begin
            bad++;
            $display("FAIL head cyc=%0d got pc=%h instr=%h want pc=%h instr=%h",
                     cyc, instr_pc, instr, exp_pc, img(exp_pc));
         end
      end
      total++;
      if (imem_req_valid !== exp_rv) begin
         bad++;
         $display("FAIL req_valid cyc=%0d got=%b want=%b", cyc, imem_req_valid, exp_rv);
      end
      total++;
      if (imem_req_addr !== exp_req_addr) begin
         bad++;
         $display("FAIL req_addr cyc=%0d got=%h want=%h", cyc, imem_req_addr, exp_req_addr);
      end
      if (imem_rsp_valid) begin
         e    = pend_q.pop_front();
         live = (e.epoch == epoch) && !redirect_valid;
         if (live) buf_cnt++;
      end
      if (pop_m) begin
         popped_q.push_back(exp_pc);
         buf_cnt--;
         exp_pc += 32'd4;
      end
      if (imem_req_valid && imem_req_ready) begin
         e.addr  = imem_req_addr;
         e.due   = cyc + int'($urandom_range(lat_max, lat_min));
         e.epoch = epoch;
         pend_q.push_back(e);
         exp_req_addr += 32'd4;
      end
      if (redirect_valid) begin
         epoch++;
         buf_cnt      = 0;
         exp_pc       = {redirect_pc[31:2], 2'b00};
         exp_req_addr = exp_pc;
      end
      total++;
      if (pend_q.size() + buf_cnt > DEPTH) begin
         bad++;
         $display("FAIL occupancy cyc=%0d got=%0d want<=%0d", cyc, pend_q.size() + buf_cnt, DEPTH);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic apply_reset();
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      instr_ready    = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_req_ready = 1'b0;
      pend_q.delete();
      popped_q.delete();
      buf_cnt      = 0;
      epoch++;
      exp_pc       = RESET_PC;
      exp_req_addr = RESET_PC;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      cyc = 0;
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      tick();
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      redirect_valid = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_req_ready = 1'b0;
      #1 rst = 1'b0;
      #1;
      total++;
      if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
         bad++;
         $display("FAIL reset_req got valid=%b addr=%h want 0 %h", imem_req_valid, imem_req_addr, RESET_PC);
      end
      total++;
      if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
         bad++;
         $display("FAIL reset_instr got valid=%b instr=%h pc=%h want 0 0 0", instr_valid, instr, instr_pc);
      end
      apply_reset();
   endtask

   task automatic test_streaming();
      int first = -1;
      lat_min = 1; lat_max = 1; mem_ready = 1'b1; instr_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (instr_valid && first < 0) first = cyc;
         tick();
      end
      total++;
      if (first !== 2) begin
         bad++;
         $display("FAIL stream_first_valid got cyc=%0d want 2", first);
      end
      total++;
      if (popped_q.size() !== 18) begin
         bad++;
         $display("FAIL stream_rate got pops=%0d want 18", popped_q.size());
      end
      for (int i = 0; i < 4 && i < popped_q.size(); i++) begin
         total++;
         if (popped_q[i] !== 32'(4 * i)) begin
            bad++;
            $display("FAIL stream_pc[%0d] got=%h want=%h", i, popped_q[i], 32'(4 * i));
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      repeat (4) tick();
      held = exp_pc;
      popped_q.delete();
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if (instr_valid !== 1'b1 || instr_pc !== held || instr !== img(held)) begin
            bad++;
            $display("FAIL bp_hold i=%0d got v=%b pc=%h instr=%h want 1 %h %h",
                     i, instr_valid, instr_pc, instr, held, img(held));
         end
         if (i >= 1) begin
            total++;
            if (imem_req_valid !== 1'b0) begin
               bad++;
               $display("FAIL bp_req_valid i=%0d got=%b want=0", i, imem_req_valid);
            end
         end
         tick();
      end
      instr_ready = 1'b1;
      repeat (10) tick();
      total++;
      if (popped_q.size() < 8 || popped_q[0] !== held) begin
         bad++;
         $display("FAIL bp_resume got n=%0d first=%h want n>=8 first=%h",
                  popped_q.size(), popped_q.size() ? popped_q[0] : 32'h0, held);
      end
      for (int i = 1; i < popped_q.size(); i++) begin
         total++;
         if (popped_q[i] !== popped_q[i-1] + 32'd4) begin
            bad++;
            $display("FAIL bp_seq[%0d] got=%h want=%h", i, popped_q[i], popped_q[i-1] + 32'd4);
         end
      end
   endtask

   task automatic test_mem_stall();
      logic [31:0] held;
      held = exp_req_addr;
      popped_q.delete();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== held) begin
            bad++;
            $display("FAIL stall_req i=%0d got v=%b addr=%h want 1 %h", i, imem_req_valid, imem_req_addr, held);
         end
         tick();
      end
      mem_ready = 1'b1;
      repeat (12) tick();
      for (int i = 1; i < popped_q.size(); i++) begin
         total++;
         if (popped_q[i] !== popped_q[i-1] + 32'd4) begin
            bad++;
            $display("FAIL stall_seq[%0d] got=%h want=%h", i, popped_q[i], popped_q[i-1] + 32'd4);
         end
      end
      total++;
      if (popped_q.size() < 6 || !popped_q.size() || popped_q[popped_q.size()-1] + 32'd4 !== exp_pc) begin
         bad++;
         $display("FAIL stall_resume got n=%0d want>=6", popped_q.size());
      end
   endtask

   task automatic test_redirect_outstanding();
      int n = 0;
      lat_min = 3; lat_max = 3; mem_ready = 1'b1; instr_ready = 1'b1;
      while (pend_q.size() != 2 && n < 20) begin tick(); n++; end
      total++;
      if (pend_q.size() != 2) begin
         bad++;
         $display("FAIL redir_setup got outstanding=%0d want 2", pend_q.size());
      end
      redirect_to(32'h0000_0102);
      popped_q.delete();
      n = 0;
      while (popped_q.size() < 2 && n < 30) begin tick(); n++; end
      total++;
      if (popped_q.size() < 2 || popped_q[0] !== 32'h100 || popped_q[1] !== 32'h104) begin
         bad++;
         $display("FAIL redir_pcs got n=%0d pc0=%h pc1=%h want 100 104", popped_q.size(),
                  popped_q.size() > 0 ? popped_q[0] : 32'h0, popped_q.size() > 1 ? popped_q[1] : 32'h0);
      end
   endtask

   task automatic test_redirect_coincident();
      int   n = 0;
      logic done = 1'b0;
      lat_min = 1; lat_max = 1; mem_ready = 1'b1; instr_ready = 1'b1;
      redirect_to(32'h20);
      while (!done && n < 20) begin
         if (instr_valid && instr_pc == 32'h20) begin
            total++;
            if (pend_q.size() == 0 || pend_q[0].addr !== 32'h24 || pend_q[0].due > cyc) begin
               bad++;
               $display("FAIL coinc_rsp got n=%0d want rsp for 24 this cycle", pend_q.size());
            end
            popped_q.delete();
            redirect_to(32'h80);
            total++;
            if (popped_q.size() != 1 || popped_q[0] !== 32'h20) begin
               bad++;
               $display("FAIL coinc_consumed got n=%0d want pop of 20", popped_q.size());
            end
            done = 1'b1;
         end else begin
            tick();
         end
         n++;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL coinc_timeout got no head 20 want head 20");
      end
      popped_q.delete();
      n = 0;
      while (popped_q.size() < 1 && n < 20) begin tick(); n++; end
      total++;
      if (popped_q.size() < 1 || popped_q[0] !== 32'h80) begin
         bad++;
         $display("FAIL coinc_next got=%h want=80", popped_q.size() ? popped_q[0] : 32'h0);
      end
   endtask

   task automatic test_wrap_reset();
      int n = 0;
      int first = -1;
      logic [31:0] want [4];
      want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0; want[3] = 32'h4;
      redirect_to(32'hFFFF_FFF8);
      popped_q.delete();
      while (popped_q.size() < 4 && n < 30) begin tick(); n++; end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (popped_q.size() <= i || popped_q[i] !== want[i]) begin
            bad++;
            $display("FAIL wrap_pc[%0d] got=%h want=%h", i, popped_q.size() > i ? popped_q[i] : 32'h0, want[i]);
         end
      end
      #2 rst = 1'b0;
      #1;
      total++;
      if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 ||
          imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
         bad++;
         $display("FAIL midreset got iv=%b i=%h pc=%h rv=%b ra=%h want 0 0 0 0 %h",
                  instr_valid, instr, instr_pc, imem_req_valid, imem_req_addr, RESET_PC);
      end
      apply_reset();
      instr_ready = 1'b1; mem_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (instr_valid && first < 0) first = cyc;
         tick();
      end
      total++;
      if (first !== 2 || popped_q.size() == 0 || popped_q[0] !== RESET_PC) begin
         bad++;
         $display("FAIL restart got first=%0d pc=%h want 2 %h", first,
                  popped_q.size() ? popped_q[0] : 32'hx, RESET_PC);
      end
   endtask

   task automatic test_random();
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         instr_ready = ($urandom_range(3, 0) != 0);
         mem_ready   = ($urandom_range(3, 0) != 0);
         if ($urandom_range(19, 0) == 0) begin
            redirect_to(($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hF) : $urandom);
         end else begin
            tick();
         end
      end
      instr_ready = 1'b1; mem_ready = 1'b1;
      repeat (20) tick();
      total++;
      if (buf_cnt != 0 && instr_valid !== 1'b1) begin
         bad++;
         $display("FAIL random_drain got valid=%b", instr_valid);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_mem_stall();
      test_redirect_outstanding();
      test_redirect_coincident();
      test_wrap_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end that sits directly upstream of the single-cycle core's instruction input.
- Generates sequential fetch addresses and issues them to an instruction memory with variable latency over a req/rsp handshake.
- Buffers returned words with their PCs in a small in-order prefetch queue and presents them to the core over a valid/ready interface.
- Accepts redirects (taken branch/jump target) from the core, flushes stale work and restarts fetch at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, prefetch queue entries; also the maximum number of requests in flight plus entries buffered (DEPTH >= 2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response word valid (in order, at least 1 cycle after acceptance).
- imem_rsp_data  input  32  response instruction word.
- redirect_valid  input  1  restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored (forced 0).
- instr_valid  output  1  head of queue valid.
- instr_ready  input  1  core consumes head.
- instr  output  32  head instruction word.
- instr_pc  output  32  PC of head instruction.

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0. Reset mid-operation drops all buffered and in-flight state; responses arriving after release for pre-reset requests are the environment's responsibility (memory is reset together with this block).
- Issue: imem_req_valid=1 when no redirect this cycle and outstanding + count - pop < DEPTH, where pop = instr_valid & instr_ready.
- On acceptance (valid & ready):
  - push fetch_pc into the in-flight PC tag FIFO (DEPTH entries);
  - fetch_pc += 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0);
  - outstanding += 1.
- imem_req_addr == fetch_pc at all times. It holds stable while valid and not ready.
- Response: on imem_rsp_valid, outstanding -= 1 and pop the tag FIFO.
  - If discard>0: discard -= 1 and drop the word.
  - Otherwise write {tag, data} into the queue; visible on instr/instr_pc the next cycle (registered).
- Output: instr_valid = (count>0). instr/instr_pc = head entry, held stable while valid and not ready. Pop on instr_valid & instr_ready. Simultaneous push and pop is allowed at any count, including full.
- Minimum latency with ready memory: request accepted cycle 0 -> response cycle 1 -> instr_valid cycle 2. Steady state is one instruction per cycle.
- Redirect (redirect_valid=1 in cycle N, priority over everything):
  - Queue flushed at the end of N. A pop handshaked in N still counts as consumed by the core.
  - No request issued in N.
  - fetch_pc = {redirect_pc[31:2], 2'b00} at N+1; first new request is presented in N+1.
  - discard = outstanding after N's accepted responses are subtracted. A response arriving in N is dropped; requests accepted before N are all discarded.
  - Tag FIFO is emptied of discarded tags as their responses drain, so stale tags never reach the queue.
  - Back-to-back redirects: the last one wins; discard accumulates correctly.
- Invariants:
  - outstanding + count <= DEPTH;
  - discard <= outstanding;
  - queue never overflows;
  - a response never arrives with outstanding=0 (assertion).
- No combinational path from instr_ready or imem_rsp_* to instr/instr_pc. imem_req_valid may depend combinationally on instr_ready and redirect_valid.

Test Plan:
- Reset streaming: release reset, memory always ready, 1-cycle latency, instr_ready=1.
  -> instr_valid first high at cycle 2 with instr_pc=0x0; then 0x4, 0x8, ... one per cycle, no gaps; instr matches memory image.
- Backpressure: instr_ready=0 for 5 cycles mid-stream.
  -> queue fills to DEPTH; imem_req_valid drops; instr/instr_pc held constant.
  -> on instr_ready=1, stream resumes with no lost or duplicated PC.
- Memory stall: imem_req_ready=0 for 3 cycles.
  -> imem_req_valid stays 1 with imem_req_addr constant; sequence continues in order afterwards.
- Redirect with 2 outstanding (3-cycle memory latency): redirect_pc=0x0000_0102.
  -> the two old responses are dropped; next instr_valid carries instr_pc=0x100, then 0x104; no stale PC is ever presented.
- Redirect coincident with response and pop: queue holds 0x20, rsp for 0x24 arrives, instr_ready=1, redirect to 0x80.
  -> 0x20 counts as consumed; 0x24 dropped; next output is 0x80.
- Wrap and reset mid-run: redirect to 0xFFFF_FFF8.
  -> PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
  -> assert rst low mid-stream: all outputs are reset values immediately; after release, fetch restarts at RESET_PC.
